// File: rtl/pipe_ctrl.sv
// Pipeline control for the if -> id -> ex core: owns the fetch PC,
// turns ex jump/hold requests into flush and stall, and tracks
// multi-cycle flush and hold sequencing.
//
// state | meaning
// RUN   | normal fetch, PC advances by 4
// FLUSH | post-jump bubble cycles, flush_o held high
// HOLD  | pipeline held by ex or bus, counting held cycles
module pipe_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned HOLD_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] jump_addr_i,
  input  logic        jump_en_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_bus_i,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        hold_timeout_o,
  output logic        jump_misalign_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [2:0]  FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [15:0] HOLD_LIMIT = 16'(HOLD_TIMEOUT);

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [2:0]  flush_cnt_q;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        timeout_q;
  logic        misalign_q;
  logic        hold;
  logic        take;

  // Request decode; jumps are ignored while held or while already flushing
  always_comb begin
    hold = hold_flag_ex_i | hold_flag_bus_i;
    take = jump_en_i & ~hold & (state_q != ST_FLUSH);
  end

  // Next PC (jump target has bit 0 cleared) and saturating hold count
  always_comb begin
    pc_d = pc_q + 32'd4;
    if (take)      pc_d = jump_addr_i & 32'hFFFF_FFFE;
    else if (hold) pc_d = pc_q;
    hold_cnt_d = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
  end

  // Control FSM with PC, counters and sticky/pulse flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      flush_cnt_q <= 3'd0;
      hold_cnt_q  <= 16'd0;
      timeout_q   <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= take & jump_addr_i[1];
      case (state_q)
        ST_RUN: begin
          if (take) begin
            if (FLUSH_CYCLES > 1) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= FLUSH_INIT;
            end
          end else if (hold) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= 16'd1;
            if (HOLD_LIMIT == 16'd1) timeout_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (!hold) begin
            if (flush_cnt_q <= 3'd1) begin
              state_q     <= ST_RUN;
              flush_cnt_q <= 3'd0;
            end else begin
              flush_cnt_q <= flush_cnt_q - 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (hold) begin
            hold_cnt_q <= hold_cnt_d;
            if (hold_cnt_d == HOLD_LIMIT) timeout_q <= 1'b1;
          end else begin
            hold_cnt_q <= 16'd0;
            // A jump re-presented in the exit cycle still needs its bubbles
            if (take && (FLUSH_CYCLES > 1)) begin
              state_q     <= ST_FLUSH;
              flush_cnt_q <= FLUSH_INIT;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  // Outputs; flush and stall are forced low while reset is asserted
  always_comb begin
    pc_o            = pc_q;
    stall_o         = hold & ~rst;
    flush_o         = (take | (state_q == ST_FLUSH)) & ~rst;
    hold_timeout_o  = timeout_q;
    jump_misalign_o = misalign_q;
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed vector bench for pipe_ctrl: instance A (FLUSH_CYCLES=1,
// HOLD_TIMEOUT=4) and instance B (FLUSH_CYCLES=2) share one stimulus.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] jump_addr;
  logic        jump_en, hold_ex, hold_bus;

  logic [31:0] a_pc, b_pc;
  logic        a_fl, a_st, a_to, a_mis;
  logic        b_fl, b_st, b_to, b_mis;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(1), .HOLD_TIMEOUT(4)) dut_a (
    .clk(clk), .rst(rst), .jump_addr_i(jump_addr), .jump_en_i(jump_en),
    .hold_flag_ex_i(hold_ex), .hold_flag_bus_i(hold_bus),
    .pc_o(a_pc), .flush_o(a_fl), .stall_o(a_st),
    .hold_timeout_o(a_to), .jump_misalign_o(a_mis)
  );

  pipe_ctrl #(.RESET_PC(32'h0), .FLUSH_CYCLES(2), .HOLD_TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .jump_addr_i(jump_addr), .jump_en_i(jump_en),
    .hold_flag_ex_i(hold_ex), .hold_flag_bus_i(hold_bus),
    .pc_o(b_pc), .flush_o(b_fl), .stall_o(b_st),
    .hold_timeout_o(b_to), .jump_misalign_o(b_mis)
  );

  typedef struct {
    logic        rst, je, ex, bus;
    logic [31:0] ja;
    logic [31:0] pc;
    logic        fl, st, to, mis;
  } vec_t;

  vec_t vec_a[$];
  vec_t vec_b[$];

  function automatic vec_t mk(logic r, logic je, logic ex, logic bus, logic [31:0] ja,
                              logic [31:0] pc, logic fl, logic st, logic to, logic mis);
    vec_t v;
    v.rst = r; v.je = je; v.ex = ex; v.bus = bus; v.ja = ja;
    v.pc = pc; v.fl = fl; v.st = st; v.to = to; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector just after a rising edge, compare on the falling edge
  task automatic apply(vec_t v, string tag, int idx, bit use_b);
    rst = v.rst; jump_en = v.je; hold_ex = v.ex; hold_bus = v.bus; jump_addr = v.ja;
    @(negedge clk);
    if (!use_b) begin
      chk($sformatf("%s%0d pc", tag, idx), a_pc, v.pc);
      chk($sformatf("%s%0d flush", tag, idx), {31'd0, a_fl}, {31'd0, v.fl});
      chk($sformatf("%s%0d stall", tag, idx), {31'd0, a_st}, {31'd0, v.st});
      chk($sformatf("%s%0d timeout", tag, idx), {31'd0, a_to}, {31'd0, v.to});
      chk($sformatf("%s%0d misalign", tag, idx), {31'd0, a_mis}, {31'd0, v.mis});
    end else begin
      chk($sformatf("%s%0d pc", tag, idx), b_pc, v.pc);
      chk($sformatf("%s%0d flush", tag, idx), {31'd0, b_fl}, {31'd0, v.fl});
      chk($sformatf("%s%0d stall", tag, idx), {31'd0, b_st}, {31'd0, v.st});
      chk($sformatf("%s%0d timeout", tag, idx), {31'd0, b_to}, {31'd0, v.to});
      chk($sformatf("%s%0d misalign", tag, idx), {31'd0, b_mis}, {31'd0, v.mis});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle();
    rst = 1'b1; jump_en = 1'b0; hold_ex = 1'b0; hold_bus = 1'b0; jump_addr = 32'h0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           rst je ex bus ja             pc            fl st to mis
    // reset wins over jump and hold
    vec_a.push_back(mk(1, 1, 1, 0, 32'h0000_0080, 32'h0000_0000, 0, 0, 0, 0));
    // sequential fetch
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0008, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_000C, 0, 0, 0, 0));
    // jump to 0x101 -> 0x100, single flush cycle
    vec_a.push_back(mk(0, 1, 0, 0, 32'h0000_0101, 32'h0000_0010, 1, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0100, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0104, 0, 0, 0, 0));
    // jump under ex hold is ignored, taken in the hold exit cycle
    vec_a.push_back(mk(0, 1, 1, 0, 32'h0000_0040, 32'h0000_0108, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 1, 1, 0, 32'h0000_0040, 32'h0000_0108, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 1, 0, 0, 32'h0000_0040, 32'h0000_0108, 1, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0040, 0, 0, 0, 0));
    // six held cycles, timeout sets at the edge closing the 4th
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0044, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0044, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0044, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0044, 0, 1, 0, 0));
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0044, 0, 1, 1, 0));
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0044, 0, 1, 1, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0044, 0, 0, 1, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0048, 0, 0, 1, 0));
    // misaligned target 0x302 still taken, one-cycle misalign pulse
    vec_a.push_back(mk(0, 1, 0, 0, 32'h0000_0302, 32'h0000_004C, 1, 0, 1, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0302, 0, 0, 1, 1));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0306, 0, 0, 1, 0));
    // jump to top of address space, then wrap to 0
    vec_a.push_back(mk(0, 1, 0, 0, 32'hFFFF_FFFC, 32'h0000_030A, 1, 0, 1, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 0, 1, 0));
    // enter HOLD, then reset mid-hold clears the sticky timeout
    vec_a.push_back(mk(0, 0, 1, 0, 32'h0,         32'h0000_0000, 0, 1, 1, 0));
    vec_a.push_back(mk(1, 1, 1, 0, 32'h0000_0080, 32'h0000_0000, 0, 0, 1, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0, 0));
    vec_a.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 0, 0));

    // FLUSH_CYCLES=2: bus hold for 3 cycles inside FLUSH, jump ignored in FLUSH
    vec_b.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0, 0));
    vec_b.push_back(mk(0, 1, 0, 0, 32'h0000_0200, 32'h0000_0004, 1, 0, 0, 0));
    vec_b.push_back(mk(0, 0, 0, 1, 32'h0,         32'h0000_0200, 1, 1, 0, 0));
    vec_b.push_back(mk(0, 0, 0, 1, 32'h0,         32'h0000_0200, 1, 1, 0, 0));
    vec_b.push_back(mk(0, 0, 0, 1, 32'h0,         32'h0000_0200, 1, 1, 0, 0));
    vec_b.push_back(mk(0, 1, 0, 0, 32'h0000_0500, 32'h0000_0200, 1, 0, 0, 0));
    vec_b.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0204, 0, 0, 0, 0));
    // reset mid-FLUSH masks flush/stall and returns to RESET_PC
    vec_b.push_back(mk(0, 1, 0, 0, 32'h0000_0300, 32'h0000_0208, 1, 0, 0, 0));
    vec_b.push_back(mk(1, 0, 0, 1, 32'h0,         32'h0000_0300, 0, 0, 0, 0));
    vec_b.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 0, 0, 0, 0));
    vec_b.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0004, 0, 0, 0, 0));

    reset_cycle();
    foreach (vec_a[i]) apply(vec_a[i], "a", i, 1'b0);

    reset_cycle();
    foreach (vec_b[i]) apply(vec_b[i], "b", i, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit and PC owner for the 3-stage core (if → id → ex).
- Consumes the execute stage's jump and hold requests, plus a bus-wait hold.
- Drives the fetch PC, the flush of if_id/id_ex, and the pipeline stall.
- Tracks multi-cycle redirect and hold sequencing with a small FSM.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- FLUSH_CYCLES, 1: cycles flush_o stays high per taken jump, counting the jump cycle; legal range 1..4. Use 2 with synchronous instruction ROM.
- HOLD_TIMEOUT, 255: consecutive held cycles after which hold_timeout_o sets; legal range 1..65535.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- jump_addr_i  in  32  target from ex.
- jump_en_i  in  1  taken jump/branch from ex, combinational.
- hold_flag_ex_i  in  1  ex multi-cycle op in progress.
- hold_flag_bus_i  in  1  instruction/data bus wait.
- pc_o  out  32  fetch address register.
- flush_o  out  1  if_id and id_ex load NOP at next edge.
- stall_o  out  1  pc, if_id and id_ex hold their values.
- hold_timeout_o  out  1  sticky error, set when hold exceeds HOLD_TIMEOUT.
- jump_misalign_o  out  1  one-cycle pulse when a taken target has bit[1]=1.

Behaviour:
Reset (rst=1 at a rising edge):
- pc_o=RESET_PC, state=RUN, flush count=0, hold count=0.
- hold_timeout_o=0, jump_misalign_o=0.
- flush_o and stall_o evaluate to 0 while rst=1.

Combinational outputs:
- hold = hold_flag_ex_i | hold_flag_bus_i.
- stall_o = hold, in every state.
- take = jump_en_i & ~hold & (state≠FLUSH).
- flush_o = take | (state==FLUSH).
- flush_o has priority over stall_o at if_id/id_ex: a stage receiving both loads NOP.

PC update, one rule per edge, highest priority first:
- take: pc_o ← {jump_addr_i[31:1],1'b0} (bit 0 cleared for JALR). jump_misalign_o ← jump_addr_i[1]. The target is still taken when misaligned.
- hold: pc_o unchanged.
- otherwise: pc_o ← pc_o+4, 32-bit wrap (32'hFFFF_FFFC → 0).
- jump_misalign_o ← 0 on every edge without take.

FSM states: RUN, FLUSH, HOLD.

RUN:
- take with FLUSH_CYCLES>1 → FLUSH, flush count ← FLUSH_CYCLES-1.
- take with FLUSH_CYCLES==1 → stay in RUN.
- hold (no take) → HOLD, hold count ← 1.

FLUSH:
- jump_en_i is ignored (ex holds a bubble).
- No hold: flush count decrements; reaching 0 → RUN.
- hold: count frozen, state stays FLUSH, flush_o stays 1, pc_o frozen.

HOLD:
- hold continues: hold count ← hold count+1, saturating at 65535.
- When hold count == HOLD_TIMEOUT while held: hold_timeout_o ← 1, cleared only by rst.
- hold drops → RUN, hold count ← 0. jump_en_i is sampled in that same cycle (take may fire in the exit cycle).

Simultaneous events:
- jump_en_i with hold: jump ignored, because the ex result is not final. ex re-presents it after the hold.
- rst with any input: reset wins, including mid-FLUSH and mid-HOLD.

Latency:
- Redirect takes effect at the edge after jump_en_i rises.
- Fetch of the target is visible on pc_o the following cycle.

Test Plan:
- Reset/sequential: rst 2 cycles, release → pc_o=0,4,8,0xC on consecutive cycles; flush_o=stall_o=0.
- Jump, FLUSH_CYCLES=1: at pc_o=0x10 pulse jump_en_i=1, jump_addr_i=0x101 → flush_o=1 that cycle only. Next cycle pc_o=0x100, then 0x104; jump_misalign_o=0.
- Jump, FLUSH_CYCLES=2, with bus hold mid-flush: jump to 0x200, then hold_flag_bus_i=1 for 3 cycles during FLUSH. flush_o stays 1 for 1+3+1 cycles. pc_o stays 0x200 during the hold, then 0x204.
- Jump with ex hold: hold_flag_ex_i=1 and jump_en_i=1 together for 2 cycles → pc_o frozen, flush_o=0, stall_o=1. Hold drops with jump_en_i=1, addr=0x40 → next pc_o=0x40.
- Timeout, HOLD_TIMEOUT=4: hold_flag_ex_i=1 for 6 cycles → hold_timeout_o rises on the edge at the 4th held cycle. It stays 1 after release; rst clears it.
- Misalign and wrap: jump to 0x302 → jump_misalign_o pulses 1 cycle, pc_o=0x302. Also jump to 0xFFFF_FFFC → pc_o=0xFFFF_FFFC, then 0x0.
